// File: rtl/as2650_wb_loader.sv
// Wishbone slave that holds the AS2650 core in reset and gives the management
// SoC byte-wide access to program memory through an arbitrated request port.
// Every output is a flop. There is one clock domain and a synchronous reset.
module as2650_wb_loader #(
  parameter int          ADDR_W    = 15,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_gnt,
  output logic              core_rst_o
);

  typedef enum logic [1:0] {IDLE, MEM, ACK} state_t;

  localparam logic [1:0]        REG_CTRL     = 2'd0;
  localparam logic [1:0]        REG_ADDR     = 2'd1;
  localparam logic [1:0]        REG_DATA     = 2'd2;
  localparam logic [7:0]        TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);

  state_t            state, state_next;
  logic [1:0]        ctrl, ctrl_next;          // bit0 core_hold, bit1 autoinc
  logic [ADDR_W-1:0] addr, addr_next;
  logic              timeout_flag, timeout_flag_next;
  logic [7:0]        wait_cnt, wait_cnt_next;

  logic              ack_next;
  logic [31:0]       dat_next;
  logic              req_next;
  logic              we_next;
  logic [ADDR_W-1:0] maddr_next;
  logic [7:0]        wdata_next;

  logic              hit;
  logic              start;
  logic [1:0]        reg_sel;
  logic              unused_bits;

  assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel = wbs_adr_i[3:2];
  // A miss or an unselected low byte is left alone so another slave can answer.
  assign start   = wbs_cyc_i & wbs_stb_i & wbs_sel_i[0] & hit & ~wbs_ack_o;

  // Bus bits this slave never looks at.
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i};

  // Next-state and next-output decode for the IDLE/MEM/ACK transaction FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    state_next        = state;
    ctrl_next         = ctrl;
    addr_next         = addr;
    timeout_flag_next = timeout_flag;
    wait_cnt_next     = wait_cnt;
    ack_next          = 1'b0;
    dat_next          = 32'h0;
    req_next          = mem_req;
    we_next           = mem_we;
    maddr_next        = mem_addr;
    wdata_next        = mem_wdata;

    case (state)
      IDLE: begin
        if (start) begin
          if (reg_sel == REG_DATA) begin
            // Launch a memory access; attributes stay frozen while mem_req is high.
            state_next    = MEM;
            req_next      = 1'b1;
            we_next       = wbs_we_i;
            maddr_next    = addr;
            wdata_next    = wbs_dat_i[7:0];
            wait_cnt_next = 8'd0;
          end else begin
            state_next = ACK;
            ack_next   = 1'b1;
            case (reg_sel)
              REG_CTRL: begin
                dat_next = {30'h0, ctrl};
                if (wbs_we_i) ctrl_next = wbs_dat_i[1:0];
              end
              REG_ADDR: begin
                dat_next = 32'(addr);
                if (wbs_we_i) addr_next = wbs_dat_i[ADDR_W-1:0];
              end
              default: begin
                // STATUS: busy always reads 0 because the bus is stalled while busy.
                dat_next = {30'h0, timeout_flag, 1'b0};
                if (wbs_we_i && wbs_dat_i[1]) timeout_flag_next = 1'b0;
              end
            endcase
          end
        end
      end

      MEM: begin
        if (!wbs_cyc_i) begin
          // Master gave up. A grant in this same cycle still completes the
          // access, but nobody is left to acknowledge.
          state_next = IDLE;
          req_next   = 1'b0;
          if (mem_gnt && ctrl[1]) addr_next = addr + ADDR_ONE;
        end else if (mem_gnt) begin
          state_next = ACK;
          req_next   = 1'b0;
          ack_next   = 1'b1;
          dat_next   = {24'h0, mem_rdata};
          if (ctrl[1]) addr_next = addr + ADDR_ONE;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          // No grant within the budget: abandon the access and flag it.
          state_next        = ACK;
          req_next          = 1'b0;
          ack_next          = 1'b1;
          dat_next          = 32'h0000_00FF;
          timeout_flag_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end

      ACK: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, register file and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (wb_rst_i) begin
      state        <= IDLE;
      ctrl         <= 2'b11;
      addr         <= '0;
      timeout_flag <= 1'b0;
      wait_cnt     <= 8'd0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= 32'h0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 8'h0;
      core_rst_o   <= 1'b1;
    end else begin
      state        <= state_next;
      ctrl         <= ctrl_next;
      addr         <= addr_next;
      timeout_flag <= timeout_flag_next;
      wait_cnt     <= wait_cnt_next;
      wbs_ack_o    <= ack_next;
      wbs_dat_o    <= dat_next;
      mem_req      <= req_next;
      mem_we       <= we_next;
      mem_addr     <= maddr_next;
      mem_wdata    <= wdata_next;
      // core_hold reaches the core one edge after the CTRL register changes.
      core_rst_o   <= ctrl[0];
    end
  end

endmodule

// File: tb/tb_as2650_wb_loader.sv
// Directed bench for as2650_wb_loader. Expected read data is queued when a
// Wishbone access is issued and checked by a monitor when the ack appears.
module tb_as2650_wb_loader;

  localparam int          ADDR_W = 15;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [1:0]  R_CTRL = 2'd0;
  localparam logic [1:0]  R_ADDR = 2'd1;
  localparam logic [1:0]  R_DATA = 2'd2;
  localparam logic [1:0]  R_STAT = 2'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cyc = 1'b0;
  logic              stb = 1'b0;
  logic              we  = 1'b0;
  logic [3:0]        sel = 4'h0;
  logic [31:0]       adr = 32'h0;
  logic [31:0]       dat_w = 32'h0;
  logic [31:0]       dat_r;
  logic              ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h0;
  logic              mem_gnt = 1'b0;
  logic              core_rst;

  typedef struct packed {
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  as2650_wb_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT(255)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_w),
    .wbs_dat_o  (dat_r),
    .wbs_ack_o  (ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_gnt    (mem_gnt),
    .core_rst_o (core_rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: every ack must match a queued access.
  always @(negedge clk) begin
    exp_t e;
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("ack_unrequested", {31'h0, ack}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) check("read_data", dat_r, e.dat);
      end
    end
  end

  task automatic push_exp(input logic c, input logic [31:0] d);
    exp_t e;
    e.chk = c;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input logic w, input logic [1:0] r, input logic [31:0] d);
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = w;
    sel   = 4'h1;
    adr   = BASE | {28'h0, r, 2'b00};
    dat_w = d;
  endtask

  task automatic drop_req();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  // Register access: ack must come exactly one cycle after the strobe and last one cycle.
  task automatic reg_access(input logic w, input logic [1:0] r, input logic [31:0] d,
                            input logic [31:0] rexp);
    int lat;
    push_exp(!w, rexp);
    @(posedge clk); #1;
    drive_req(w, r, d);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ack !== 1'b1 && lat < 10);
    check("reg_ack_latency", 32'(lat), 32'd1);
    drop_req();
    @(posedge clk); #1;
    check("reg_ack_width", {31'h0, ack}, 32'h0);
  endtask

  // DATA access: grant is given in the gnt_at-th cycle of mem_req (0 = never).
  task automatic mem_access(input logic w, input logic [7:0] wd, input int gnt_at,
                            input logic [7:0] rd, input logic [ADDR_W-1:0] exp_addr,
                            input int exp_cycles, input logic [31:0] rexp);
    int   lat;
    int   req_cnt;
    logic attr_ok;
    push_exp(!w || gnt_at == 0, rexp);
    @(posedge clk); #1;
    drive_req(w, R_DATA, {24'h0, wd});
    lat     = 0;
    req_cnt = 0;
    attr_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      mem_gnt = 1'b0;
      if (ack !== 1'b1 && mem_req === 1'b1) begin
        req_cnt++;
        if (mem_addr !== exp_addr || mem_we !== w || (w && mem_wdata !== wd)) attr_ok = 1'b0;
        if (req_cnt == gnt_at) begin
          mem_gnt   = 1'b1;
          mem_rdata = rd;
        end
      end
    end while (ack !== 1'b1 && lat < 400);
    check("mem_req_cycles", 32'(req_cnt), 32'(exp_cycles));
    check("mem_attrs", {31'h0, attr_ok}, 32'h1);
    check("mem_ack_latency", 32'(lat), 32'(exp_cycles + 1));
    check("mem_req_low_at_ack", {31'h0, mem_req}, 32'h0);
    drop_req();
    @(posedge clk); #1;
    check("mem_ack_width", {31'h0, ack}, 32'h0);
  endtask

  initial begin
    int busy;

    // 1. Reset values, then register reads with ack timing.
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_rst", {31'h0, core_rst}, 32'h1);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dat", dat_r, 32'h0);
    rst = 1'b0;
    reg_access(1'b0, R_CTRL, 32'h0, 32'h3);
    reg_access(1'b0, R_ADDR, 32'h0, 32'h0);
    reg_access(1'b0, R_STAT, 32'h0, 32'h0);
    check("core_rst_after_release", {31'h0, core_rst}, 32'h1);

    // Address miss and sel[0]=0 must be ignored completely.
    @(posedge clk); #1;
    drive_req(1'b1, R_DATA, 32'h55);
    adr  = 32'h3000_0018;
    busy = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack === 1'b1 || mem_req === 1'b1) busy++;
    end
    adr = BASE | 32'h8;
    sel = 4'he;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack === 1'b1 || mem_req === 1'b1) busy++;
    end
    drop_req();
    check("ignored_access_activity", 32'(busy), 32'h0);

    // 2. Memory write with grant in the third request cycle, autoinc on.
    reg_access(1'b1, R_ADDR, 32'h0000_0100, 32'h0);
    mem_access(1'b1, 8'hA5, 3, 8'h00, 15'h0100, 3, 32'h0);
    reg_access(1'b0, R_ADDR, 32'h0, 32'h0000_0101);

    // 3. Memory read at the top address; ADDR wraps to zero.
    reg_access(1'b1, R_ADDR, 32'h0000_7FFF, 32'h0);
    mem_access(1'b0, 8'h00, 1, 8'h3C, 15'h7FFF, 1, 32'h0000_003C);
    reg_access(1'b0, R_ADDR, 32'h0, 32'h0);

    // 4. No grant: timeout after 255 cycles, sticky flag, ADDR unchanged.
    reg_access(1'b1, R_ADDR, 32'h0000_0200, 32'h0);
    mem_access(1'b0, 8'h00, 0, 8'h00, 15'h0200, 255, 32'h0000_00FF);
    reg_access(1'b0, R_STAT, 32'h0, 32'h2);
    reg_access(1'b0, R_ADDR, 32'h0, 32'h0000_0200);
    reg_access(1'b1, R_STAT, 32'h2, 32'h0);
    reg_access(1'b0, R_STAT, 32'h0, 32'h0);

    // 5a. Cycle dropped in the second MEM cycle: no ack, no autoinc.
    @(posedge clk); #1;
    drive_req(1'b0, R_DATA, 32'h0);
    @(posedge clk); #1;
    check("abort_req_up", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    drop_req();
    @(posedge clk); #1;
    check("abort_req_drop", {31'h0, mem_req}, 32'h0);
    repeat (2) @(posedge clk);
    reg_access(1'b0, R_ADDR, 32'h0, 32'h0000_0200);

    // 5b. Grant coincident with the cycle drop: counts as complete, still no ack.
    @(posedge clk); #1;
    drive_req(1'b0, R_DATA, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drop_req();
    mem_gnt   = 1'b1;
    mem_rdata = 8'h77;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("abort_gnt_req_drop", {31'h0, mem_req}, 32'h0);
    repeat (2) @(posedge clk);
    reg_access(1'b0, R_ADDR, 32'h0, 32'h0000_0201);

    // 6. Release the core, then reset in the middle of a memory access.
    reg_access(1'b1, R_CTRL, 32'h0, 32'h0);
    check("core_released", {31'h0, core_rst}, 32'h0);
    reg_access(1'b0, R_CTRL, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive_req(1'b1, R_DATA, 32'h11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_req", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    drop_req();
    @(posedge clk); #1;
    check("reset_mid_mem_req", {31'h0, mem_req}, 32'h0);
    check("reset_mid_mem_core_rst", {31'h0, core_rst}, 32'h1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    reg_access(1'b0, R_CTRL, 32'h0, 32'h3);
    reg_access(1'b0, R_ADDR, 32'h0, 32'h0);
    reg_access(1'b0, R_STAT, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
